// File: rtl/simd_vec_engine_if.sv
// Operand/instruction handshake and result bundle for simd_vec_engine.
// master = operand stream / writeback side, slave = the engine.
interface simd_vec_engine_if #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32,
    parameter int CNT_W  = 6
) ();
    logic                    valid_instruction;
    logic [2:0]              instruction;
    logic [CNT_W-1:0]        data_size;
    logic                    valid_data;
    logic                    ready;
    logic [LANES*LANE_W-1:0] mc_data_in_opa;
    logic [LANES*LANE_W-1:0] mc_data_in_opb;
    logic                    out_valid;
    logic [LANES*LANE_W-1:0] out_data;
    logic [LANES*LANE_W-1:0] out_extra;
    logic                    busy;
    logic                    done;

    modport master (
        output valid_instruction, instruction, data_size, valid_data,
               mc_data_in_opa, mc_data_in_opb,
        input  ready, out_valid, out_data, out_extra, busy, done
    );

    modport slave (
        input  valid_instruction, instruction, data_size, valid_data,
               mc_data_in_opa, mc_data_in_opb,
        output ready, out_valid, out_data, out_extra, busy, done
    );
endinterface

// File: rtl/simd_vec_engine.sv
// LANES x LANE_W SIMD vector engine: beat counter, input reg -> compute reg -> output reg.
// Optional macro SIMD_SAT_EN: saturating ADD/SUB with saturation flag in extra bit 0.
module simd_vec_engine #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32,
    parameter int CNT_W  = 6
) (
    input logic              clk,
    input logic              reset,
    simd_vec_engine_if.slave bus
);
    localparam int VW = LANES * LANE_W;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_MAC = 3'b110;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t           r_state, w_state_nxt;
    logic             w_ready, w_start, w_accept;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_s1_valid, r_s1_last, r_s2_valid, r_s2_last;
    logic [VW-1:0]    r_s1_a, r_s1_b;
    logic [VW-1:0]    w_s2_data, w_s2_extra;
    logic             r_out_valid, r_done, r_busy;
    logic [VW-1:0]    r_out_data, r_out_extra;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.valid_instruction && (bus.data_size != '0)) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_ready = 1'b1;
                if (bus.valid_data && (r_cnt == CNT_W'(1))) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!r_s1_valid && !r_s2_valid) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept = w_ready & bus.valid_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op        <= '0;
            r_cnt       <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_last   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_extra <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_start) begin
                r_op  <= bus.instruction;
                r_cnt <= bus.data_size;
            end else if (w_accept) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            r_s1_valid <= w_accept;
            r_s1_last  <= w_accept && (r_cnt == CNT_W'(1));
            if (w_accept) begin
                r_s1_a <= bus.mc_data_in_opa;
                r_s1_b <= bus.mc_data_in_opb;
            end
            r_s2_valid  <= r_s1_valid;
            r_s2_last   <= r_s1_valid & r_s1_last;
            r_out_valid <= r_s2_valid;
            r_done      <= r_s2_valid & r_s2_last;
            if (r_s2_valid) begin
                r_out_data  <= w_s2_data;
                r_out_extra <= w_s2_extra;
            end
            // busy covers the done cycle itself and falls on the following edge
            if (w_start)     r_busy <= 1'b1;
            else if (r_done) r_busy <= 1'b0;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LANE_W-1:0]   w_a, w_b;
        logic [LANE_W:0]     w_sum, w_dif;
        logic [2*LANE_W-1:0] w_prod, w_mac, w_res;
        logic [2*LANE_W-1:0] r_acc, r_res;

        assign w_a    = r_s1_a[g*LANE_W +: LANE_W];
        assign w_b    = r_s1_b[g*LANE_W +: LANE_W];
        assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
        // top bit of the widened difference is the borrow
        assign w_dif  = {1'b0, w_a} - {1'b0, w_b};
        assign w_prod = {{LANE_W{1'b0}}, w_a} * {{LANE_W{1'b0}}, w_b};
        assign w_mac  = r_acc + w_prod;

        always_comb begin
            w_res = '0;
            case (r_op)
`ifdef SIMD_SAT_EN
                OP_ADD: w_res = w_sum[LANE_W] ? {{(LANE_W-1){1'b0}}, 1'b1, {LANE_W{1'b1}}}
                                              : {{LANE_W{1'b0}}, w_sum[LANE_W-1:0]};
                OP_SUB: w_res = w_dif[LANE_W] ? {{(LANE_W-1){1'b0}}, 1'b1, {LANE_W{1'b0}}}
                                              : {{LANE_W{1'b0}}, w_dif[LANE_W-1:0]};
`else
                OP_ADD: w_res = {{(LANE_W-1){1'b0}}, w_sum};
                OP_SUB: w_res = {{(LANE_W-1){1'b0}}, w_dif};
`endif
                OP_AND: w_res = {{LANE_W{1'b0}}, w_a & w_b};
                OP_OR:  w_res = {{LANE_W{1'b0}}, w_a | w_b};
                OP_XOR: w_res = {{LANE_W{1'b0}}, w_a ^ w_b};
                OP_MUL: w_res = w_prod;
                OP_MAC: w_res = w_mac;
                default: w_res = '0;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_acc <= '0;
                r_res <= '0;
            end else begin
                if (w_start)                         r_acc <= '0;
                else if (r_s1_valid && r_op == OP_MAC) r_acc <= w_mac;
                if (r_s1_valid) r_res <= w_res;
            end
        end

        assign w_s2_data[g*LANE_W +: LANE_W]  = r_res[LANE_W-1:0];
        assign w_s2_extra[g*LANE_W +: LANE_W] = r_res[2*LANE_W-1:LANE_W];
    end

    assign bus.ready     = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_extra = r_out_extra;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_simd_vec_engine.sv
// Randomised bench for simd_vec_engine against a per-beat arithmetic reference model.
module tb_simd_vec_engine;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    simd_vec_engine_if #(.LANES(4), .LANE_W(32), .CNT_W(6)) bus ();

    simd_vec_engine #(.LANES(4), .LANE_W(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] data;
        logic [127:0] extra;
        bit           last;
        int           cyc;
    } exp_t;

    exp_t            exp_q[$];
    logic [127:0]    beat_a[$];
    logic [127:0]    beat_b[$];
    bit              vpat[$];
    longint unsigned acc[4];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void model_beat(input logic [2:0] op, input logic [127:0] a,
                                       input logic [127:0] b, input bit last, input int c);
        exp_t            e;
        longint unsigned x, y, p, s;
        logic [31:0]     lo, hi;
        e.data  = '0;
        e.extra = '0;
        for (int i = 0; i < 4; i++) begin
            x  = 64'(a[i*32 +: 32]);
            y  = 64'(b[i*32 +: 32]);
            p  = x * y;
            lo = 32'h0;
            hi = 32'h0;
            case (op)
                3'd0: begin
                    s  = x + y;
                    lo = s[31:0];
                    hi = s[63:32];
`ifdef SIMD_SAT_EN
                    if (hi != 0) lo = 32'hFFFF_FFFF;
`endif
                end
                3'd1: begin
                    s  = x - y;
                    lo = s[31:0];
                    hi = (x < y) ? 32'd1 : 32'd0;
`ifdef SIMD_SAT_EN
                    if (x < y) lo = 32'h0;
`endif
                end
                3'd2: lo = 32'(x & y);
                3'd3: lo = 32'(x | y);
                3'd4: lo = 32'(x ^ y);
                3'd5: begin lo = p[31:0]; hi = p[63:32]; end
                3'd6: begin
                    acc[i] = acc[i] + p;
                    s  = acc[i];
                    lo = s[31:0];
                    hi = s[63:32];
                end
                default: ;
            endcase
            e.data[i*32 +: 32]  = lo;
            e.extra[i*32 +: 32] = hi;
        end
        e.last = last;
        e.cyc  = c;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", bus.out_data, e.data);
                    chk("out_extra", bus.out_extra, e.extra);
                    chk("done", 128'(bus.done), 128'(e.last));
                    chk("latency_cycle", 128'(cyc), 128'(e.cyc + 2));
                    if (e.last) chk("busy_at_done", 128'(bus.busy), 1);
                end
            end else if (bus.done) begin
                chk("done_without_valid", 128'(bus.done), 0);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input int n);
        bus.valid_instruction = 1'b1;
        bus.instruction       = op;
        bus.data_size         = 6'(n);
        for (int i = 0; i < 4; i++) acc[i] = 0;
        @(posedge clk); #1;
        bus.valid_instruction = 1'b0;
        bus.instruction       = 3'($urandom);
        bus.data_size         = 6'($urandom);
    endtask

    task automatic run_instr(input logic [2:0] op, input int n);
        int sent;
        int guard;
        bit v;
        issue(op, n);
        if (n == 0) begin
            for (int i = 0; i < 4; i++) begin
                chk("size0_busy", 128'(bus.busy), 0);
                chk("size0_ready", 128'(bus.ready), 0);
                @(posedge clk); #1;
            end
            return;
        end
        chk("busy_after_issue", 128'(bus.busy), 1);
        sent = 0;
        while (sent < n) begin
            if (vpat.size() > 0) v = vpat.pop_front();
            else                 v = ($urandom_range(0, 3) != 0);
            bus.valid_data     = v;
            bus.mc_data_in_opa = (v && beat_a.size() > 0) ? beat_a.pop_front() : rnd128();
            bus.mc_data_in_opb = (v && beat_b.size() > 0) ? beat_b.pop_front() : rnd128();
            chk("ready_in_run", 128'(bus.ready), 1);
            @(posedge clk); #1;
            if (v) begin
                model_beat(op, bus.mc_data_in_opa, bus.mc_data_in_opb, sent == n - 1, cyc);
                sent++;
            end
        end
        bus.valid_data = 1'b0;
        chk("ready_after_last", 128'(bus.ready), 0);
        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("drain_timeout", 128'(guard < 50), 1);
        chk("busy_after_done", 128'(bus.busy), 0);
        chk("done_cleared", 128'(bus.done), 0);
    endtask

    initial begin
        bus.valid_instruction = 1'b0;
        bus.instruction       = '0;
        bus.data_size         = '0;
        bus.valid_data        = 1'b0;
        bus.mc_data_in_opa    = '0;
        bus.mc_data_in_opb    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 128'(bus.ready), 0);
        chk("rst_out_valid", 128'(bus.out_valid), 0);
        chk("rst_busy", 128'(bus.busy), 0);
        chk("rst_done", 128'(bus.done), 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_extra", bus.out_extra, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // ADD carry out on every lane
        beat_a.push_back({4{32'hFFFF_FFFF}});
        beat_b.push_back({4{32'h0000_0001}});
        vpat.push_back(1'b1);
        run_instr(3'd0, 1);

        // MUL full-width products
        beat_a.push_back({4{32'h0001_0000}});
        beat_b.push_back({4{32'h0001_0000}});
        beat_a.push_back({4{32'h1234_5678}});
        beat_b.push_back({4{32'h0000_0002}});
        vpat = '{1, 1};
        run_instr(3'd5, 2);

        // MAC accumulation 6, 12, 18
        for (int i = 0; i < 3; i++) begin
            beat_a.push_back({4{32'd2}});
            beat_b.push_back({4{32'd3}});
        end
        vpat = '{1, 1, 1};
        run_instr(3'd6, 3);

        // backpressure gaps
        vpat = '{1, 0, 1, 1, 0, 1};
        run_instr(3'd4, 4);

        // zero-length vector is ignored
        run_instr(3'd0, 0);

        // reset in the middle of a 5-beat instruction
        issue(3'd0, 5);
        for (int i = 0; i < 2; i++) begin
            bus.valid_data     = 1'b1;
            bus.mc_data_in_opa = rnd128();
            bus.mc_data_in_opb = rnd128();
            @(posedge clk); #1;
        end
        bus.valid_data = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", 128'(bus.out_valid), 0);
        chk("midrst_out_data", bus.out_data, 0);
        chk("midrst_out_extra", bus.out_extra, 0);
        chk("midrst_busy", 128'(bus.busy), 0);
        chk("midrst_ready", 128'(bus.ready), 0);
        chk("midrst_done", 128'(bus.done), 0);
        exp_q.delete();
        reset = 1'b0;
        @(posedge clk); #1;
        run_instr(3'd0, 3);

        for (int t = 0; t < 30; t++) begin
            run_instr(3'($urandom_range(0, 7)), $urandom_range(1, 8));
        end

        chk("queue_empty_at_end", 128'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
